// File: rtl/omsp_spm_cmd_seq_pkg.sv
// Shared op codes and FSM encodings for the SPM command sequencer.
// The optional KEYGEN timeout is built only with OMSP_SPM_KDF_TIMEOUT_EN (default: undefined).
package omsp_spm_cmd_seq_pkg;

    localparam logic [1:0] SPM_OP_PROTECT   = 2'b00;
    localparam logic [1:0] SPM_OP_UNPROTECT = 2'b01;
    localparam logic [1:0] SPM_OP_ATTEST    = 2'b10;
    localparam logic [1:0] SPM_OP_RSVD      = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_STROBE = 3'd1;
    localparam logic [2:0] ST_KSTART = 3'd2;
    localparam logic [2:0] ST_KEYGEN = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    function automatic logic op_is_rsvd(input logic [1:0] op);
        return op == SPM_OP_RSVD;
    endfunction

endpackage

// File: rtl/omsp_spm_cmd_seq_if.sv
// Command req/ack handshake between the execution unit and the sequencer.
// Built the same with or without OMSP_SPM_KDF_TIMEOUT_EN.
interface omsp_spm_cmd_seq_if;

    logic       cmd_req;
    logic [1:0] cmd_op;
    logic       cmd_ack;
    logic       cmd_err;
    logic       busy;

    modport master (
        output cmd_req, cmd_op,
        input  cmd_ack, cmd_err, busy
    );

    modport slave (
        input  cmd_req, cmd_op,
        output cmd_ack, cmd_err, busy
    );

endinterface

// File: rtl/omsp_spm_key_stream.sv
// Key word stream: word counter, kdf handshake, last-word detect.
// OMSP_SPM_KDF_TIMEOUT_EN adds a KEYGEN cycle counter that flags a timeout.
module omsp_spm_key_stream #(
    parameter int KEY_IDX_SIZE = 3
`ifdef OMSP_SPM_KDF_TIMEOUT_EN
  , parameter int KDF_TIMEOUT  = 255
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_active,
    input  logic                    i_kdf_valid,
    input  logic [15:0]             i_kdf_data,
    output logic                    o_kdf_ready,
    output logic                    o_write_key,
    output logic [15:0]             o_key_in,
    output logic [KEY_IDX_SIZE-1:0] o_key_idx,
    output logic                    o_last,
    output logic                    o_timeout
);

    logic [KEY_IDX_SIZE-1:0] r_cnt;
    logic                    w_word;

    assign w_word      = i_active & i_kdf_valid;
    assign o_kdf_ready = i_active;
    assign o_write_key = w_word;
    assign o_key_in    = i_kdf_data;
    assign o_key_idx   = i_active ? r_cnt : '0;
    assign o_last      = w_word & (r_cnt == {KEY_IDX_SIZE{1'b1}});

    // Wraps to 0 after the final word; cleared again on the next KSTART.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_word) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef OMSP_SPM_KDF_TIMEOUT_EN
    localparam int TW = $clog2(KDF_TIMEOUT + 1);

    logic [TW-1:0] r_tcnt;

    assign o_timeout = i_active & ~o_last &
                       (r_tcnt == TW'(KDF_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (i_clr) begin
            r_tcnt <= '0;
        end else if (i_active) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/omsp_spm_cmd_seq.sv
// SPM command sequencer: protect/unprotect/attest strobes plus key streaming.
// Define OMSP_SPM_KDF_TIMEOUT_EN to bound KEYGEN by KDF_TIMEOUT cycles.
module omsp_spm_cmd_seq
    import omsp_spm_cmd_seq_pkg::*;
#(
    parameter int KEY_IDX_SIZE = 3
`ifdef OMSP_SPM_KDF_TIMEOUT_EN
  , parameter int KDF_TIMEOUT  = 255
`endif
) (
    input  logic                    mclk,
    input  logic                    puc_rst_n,
    omsp_spm_cmd_seq_if.slave       cmd,
    output logic                    update_spm,
    output logic                    enable_spm,
    output logic                    disable_spm,
    output logic                    verify_spm,
    input  logic                    violation,
    output logic                    kdf_start,
    input  logic                    kdf_valid,
    output logic                    kdf_ready,
    input  logic [15:0]             kdf_data,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx
);

    logic [2:0] r_state;
    logic [1:0] r_op;
    logic       r_err;
    logic       w_strobe;
    logic       w_last;
    logic       w_timeout;

    assign w_strobe    = (r_state == ST_STROBE);
    assign update_spm  = w_strobe & ((r_op == SPM_OP_PROTECT) |
                                     (r_op == SPM_OP_UNPROTECT));
    assign enable_spm  = w_strobe & (r_op == SPM_OP_PROTECT);
    assign disable_spm = w_strobe & (r_op == SPM_OP_UNPROTECT);
    assign verify_spm  = w_strobe & (r_op == SPM_OP_ATTEST);
    assign kdf_start   = (r_state == ST_KSTART);
    assign cmd.cmd_ack = (r_state == ST_DONE);
    assign cmd.cmd_err = cmd.cmd_ack & r_err;
    assign cmd.busy    = (r_state != ST_IDLE);

    omsp_spm_key_stream #(
        .KEY_IDX_SIZE (KEY_IDX_SIZE)
`ifdef OMSP_SPM_KDF_TIMEOUT_EN
      , .KDF_TIMEOUT  (KDF_TIMEOUT)
`endif
    ) u_key_stream (
        .clk         (mclk),
        .rst_n       (puc_rst_n),
        .i_clr       (kdf_start),
        .i_active    (r_state == ST_KEYGEN),
        .i_kdf_valid (kdf_valid),
        .i_kdf_data  (kdf_data),
        .o_kdf_ready (kdf_ready),
        .o_write_key (write_key),
        .o_key_in    (key_in),
        .o_key_idx   (key_idx),
        .o_last      (w_last),
        .o_timeout   (w_timeout)
    );

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= SPM_OP_PROTECT;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (cmd.cmd_req) begin
                        r_op <= cmd.cmd_op;
                        if (op_is_rsvd(cmd.cmd_op)) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_STROBE;
                        end
                    end
                end
                ST_STROBE: begin
                    if (violation) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_op == SPM_OP_PROTECT) begin
                        r_state <= ST_KSTART;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_KSTART: r_state <= ST_KEYGEN;
                ST_KEYGEN: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Directed bench for omsp_spm_cmd_seq: vector table plus protect sequences.
// The timeout sequence runs only when OMSP_SPM_KDF_TIMEOUT_EN is defined.
module tb_omsp_spm_cmd_seq;

    logic        mclk = 1'b0;
    logic        puc_rst_n;
    logic        update_spm, enable_spm, disable_spm, verify_spm;
    logic        violation;
    logic        kdf_start, kdf_valid, kdf_ready, write_key;
    logic [15:0] kdf_data, key_in;
    logic [2:0]  key_idx;

    int n_chk = 0;
    int n_err = 0;

    omsp_spm_cmd_seq_if cif ();

    omsp_spm_cmd_seq #(
        .KEY_IDX_SIZE (3)
`ifdef OMSP_SPM_KDF_TIMEOUT_EN
      , .KDF_TIMEOUT  (16)
`endif
    ) dut (
        .mclk        (mclk),
        .puc_rst_n   (puc_rst_n),
        .cmd         (cif),
        .update_spm  (update_spm),
        .enable_spm  (enable_spm),
        .disable_spm (disable_spm),
        .verify_spm  (verify_spm),
        .violation   (violation),
        .kdf_start   (kdf_start),
        .kdf_valid   (kdf_valid),
        .kdf_ready   (kdf_ready),
        .kdf_data    (kdf_data),
        .write_key   (write_key),
        .key_in      (key_in),
        .key_idx     (key_idx)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [1:0] op;
        logic       viol;
        logic [3:0] strb;
        int         ack_c;
        logic       err;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {update_spm, enable_spm, disable_spm, verify_spm};
    endfunction

    task automatic chk_all_zero(input string nm);
        chk({nm, "_strb"}, {28'd0, strobes()}, 32'd0);
        chk({nm, "_ack"}, {31'd0, cif.cmd_ack}, 32'd0);
        chk({nm, "_err"}, {31'd0, cif.cmd_err}, 32'd0);
        chk({nm, "_busy"}, {31'd0, cif.busy}, 32'd0);
        chk({nm, "_kstart"}, {31'd0, kdf_start}, 32'd0);
        chk({nm, "_kready"}, {31'd0, kdf_ready}, 32'd0);
        chk({nm, "_wkey"}, {31'd0, write_key}, 32'd0);
        chk({nm, "_kidx"}, {29'd0, key_idx}, 32'd0);
        chk({nm, "_keyin"}, {16'd0, key_in}, {16'd0, kdf_data});
    endtask

    task automatic send(input logic [1:0] op);
        @(negedge mclk);
        cif.cmd_req = 1'b1;
        cif.cmd_op  = op;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic v;

        vt[0] = '{2'b01, 1'b0, 4'b1010, 2, 1'b0};
        vt[1] = '{2'b10, 1'b0, 4'b0001, 2, 1'b0};
        vt[2] = '{2'b11, 1'b0, 4'b0000, 1, 1'b1};
        vt[3] = '{2'b00, 1'b1, 4'b1100, 2, 1'b1};
        vt[4] = '{2'b01, 1'b1, 4'b1010, 2, 1'b1};
        vt[5] = '{2'b10, 1'b1, 4'b0001, 2, 1'b1};

        puc_rst_n   = 1'b0;
        cif.cmd_req = 1'b0;
        cif.cmd_op  = 2'b00;
        violation   = 1'b0;
        kdf_valid   = 1'b0;
        kdf_data    = 16'hA5C3;
        repeat (2) @(negedge mclk);
        chk_all_zero("reset");
        puc_rst_n = 1'b1;

        // Single-strobe commands and violation cases.
        for (int i = 0; i < 6; i++) begin
            send(vt[i].op);
            for (int c = 1; c <= 3; c++) begin
                @(negedge mclk);
                if (c == 1) begin
                    cif.cmd_req = 1'b0;
                    chk("vec_strobe", {28'd0, strobes()}, {28'd0, vt[i].strb});
                end else begin
                    chk("vec_nostrobe", {28'd0, strobes()}, 32'd0);
                end
                chk("vec_ack", {31'd0, cif.cmd_ack},
                    {31'd0, c == vt[i].ack_c});
                chk("vec_err", {31'd0, cif.cmd_err},
                    {31'd0, (c == vt[i].ack_c) && vt[i].err});
                chk("vec_busy", {31'd0, cif.busy},
                    {31'd0, c <= vt[i].ack_c});
                chk("vec_kstart", {31'd0, kdf_start}, 32'd0);
                violation = (c == 1) ? vt[i].viol : 1'b0;
            end
            violation = 1'b0;
        end

        // Protect with kdf_valid constantly high.
        kdf_valid = 1'b1;
        kdf_data  = 16'h1000;
        send(2'b00);
        for (int c = 1; c <= 11; c++) begin
            @(negedge mclk);
            if (c == 1) cif.cmd_req = 1'b0;
            kdf_data = 16'h1000 + 16'((c >= 3 && c <= 10) ? c - 3 : 0);
            #1;
            if (c == 1) chk("p_strobe", {28'd0, strobes()}, 32'h0000000C);
            chk("p_kstart", {31'd0, kdf_start}, {31'd0, c == 2});
            chk("p_wkey", {31'd0, write_key}, {31'd0, c >= 3 && c <= 10});
            if (c >= 3 && c <= 10) begin
                chk("p_kidx", {29'd0, key_idx}, 32'(c - 3));
                chk("p_keyin", {16'd0, key_in}, 32'h1000 + 32'(c - 3));
                chk("p_kready", {31'd0, kdf_ready}, 32'd1);
            end
            chk("p_ack", {31'd0, cif.cmd_ack}, {31'd0, c == 11});
            if (c == 11) chk("p_err", {31'd0, cif.cmd_err}, 32'd0);
        end
        kdf_valid = 1'b0;

        // Protect with kdf_valid toggling 1,0,1,0 from KEYGEN entry.
        cnt = 0;
        send(2'b00);
        for (int c = 1; c <= 18; c++) begin
            @(negedge mclk);
            if (c == 1) cif.cmd_req = 1'b0;
            v = (c >= 3) && (((c - 3) % 2) == 0);
            kdf_valid = v;
            kdf_data  = 16'h2000 + 16'(cnt);
            #1;
            chk("t_wkey", {31'd0, write_key}, {31'd0, v});
            if (v) begin
                chk("t_kidx", {29'd0, key_idx}, 32'(cnt));
                chk("t_keyin", {16'd0, key_in}, 32'h2000 + 32'(cnt));
                cnt++;
            end
            chk("t_ack", {31'd0, cif.cmd_ack}, {31'd0, c == 18});
        end
        chk("t_words", 32'(cnt), 32'd8);
        kdf_valid = 1'b0;

        // Reset while streaming word 4, then an attest.
        kdf_valid = 1'b1;
        send(2'b00);
        for (int c = 1; c <= 7; c++) begin
            @(negedge mclk);
            if (c == 1) cif.cmd_req = 1'b0;
        end
        chk("r_kidx_pre", {29'd0, key_idx}, 32'd4);
        puc_rst_n = 1'b0;
        #1;
        chk_all_zero("r_mid");
        @(negedge mclk);
        puc_rst_n = 1'b1;
        kdf_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge mclk);
            chk("r_idle_ack", {31'd0, cif.cmd_ack}, 32'd0);
            chk("r_idle_busy", {31'd0, cif.busy}, 32'd0);
        end
        send(2'b10);
        for (int c = 1; c <= 2; c++) begin
            @(negedge mclk);
            if (c == 1) begin
                cif.cmd_req = 1'b0;
                chk("r_att_strb", {28'd0, strobes()}, 32'd1);
            end
            chk("r_att_ack", {31'd0, cif.cmd_ack}, {31'd0, c == 2});
            chk("r_att_err", {31'd0, cif.cmd_err}, 32'd0);
        end

`ifdef OMSP_SPM_KDF_TIMEOUT_EN
        // KEYGEN entered at T+3; stuck kdf_valid times out after 16 cycles.
        kdf_valid = 1'b0;
        send(2'b00);
        for (int c = 1; c <= 19; c++) begin
            @(negedge mclk);
            if (c == 1) cif.cmd_req = 1'b0;
            chk("to_wkey", {31'd0, write_key}, 32'd0);
            chk("to_kready", {31'd0, kdf_ready}, {31'd0, c >= 3 && c <= 18});
            chk("to_ack", {31'd0, cif.cmd_ack}, {31'd0, c == 19});
            if (c == 19) chk("to_err", {31'd0, cif.cmd_err}, 32'd1);
        end
`endif

        @(negedge mclk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/omsp_spm_cmd_seq.md
# omsp_spm_cmd_seq

Command sequencer in front of the SPM control array. It takes one protect, unprotect or attest command at a time from the execution unit over a req/ack handshake. For each command it drives the single-cycle `update_spm`/`enable_spm`/`disable_spm`/`verify_spm` strobes and samples `violation`. For protect, it also streams the derived module key from the key-derivation engine into the array word by word via `write_key`/`key_idx`.

## Interface
- `KEY_IDX_SIZE`, 3: width of `key_idx`; key length is 2^KEY_IDX_SIZE 16-bit words.
- `KDF_TIMEOUT`, 255: maximum cycles spent in KEYGEN (used only with the timeout feature).
- `mclk` in 1: clock (one clock domain).
- `puc_rst_n` in 1: reset, asynchronous, active-low.
- `cmd_req` in 1: command request; held high until `cmd_ack`.
- `cmd_op` in 2: 00 protect, 01 unprotect, 10 attest, 11 reserved; stable while `cmd_req` is high.
- `cmd_ack` out 1: one-cycle completion pulse.
- `cmd_err` out 1: error flag, valid only while `cmd_ack` is high.
- `busy` out 1: high whenever state ≠ IDLE.
- `update_spm`, `enable_spm`, `disable_spm`, `verify_spm` out 1 each: strobes to the SPM control array.
- `violation` in 1: SPM array violation, sampled in the strobe cycle.
- `kdf_start` out 1: one-cycle pulse that starts key derivation.
- `kdf_valid` in 1 / `kdf_ready` out 1 / `kdf_data` in 16: key word stream.
- `write_key` out 1, `key_in` out 16, `key_idx` out KEY_IDX_SIZE: key write port to the SPM array.

## Operation
- States: IDLE, STROBE, KSTART, KEYGEN, DONE. Encoding is binary and registered.
- IDLE:
  - If `cmd_req` is high, register `cmd_op`.
  - Ops 00/01/10 go to STROBE.
  - Op 11 goes to DONE with the error flag set.
- STROBE (exactly one cycle):
  - Protect: `update_spm=1`, `enable_spm=1`.
  - Unprotect: `update_spm=1`, `disable_spm=1`, `enable_spm=0`.
  - Attest: `verify_spm=1`.
  - If `violation` is high in this cycle: set the error flag and go to DONE.
  - Otherwise protect goes to KSTART; the other ops go to DONE.
- KSTART (one cycle): `kdf_start=1`, word counter cleared to 0, then go to KEYGEN.
- KEYGEN:
  - `kdf_ready=1`.
  - `write_key = kdf_valid`, which is combinational from the input.
  - `key_in = kdf_data`; `key_idx` = counter.
  - Each cycle with `kdf_valid`: counter increments.
  - On the word where counter = 2^KEY_IDX_SIZE−1: go to DONE. The counter wraps to 0 and is not reused.
- DONE: `cmd_ack=1` for one cycle, `cmd_err` = error flag, then go to IDLE and clear the error flag.
- Requester rules:
  - The requester drops `cmd_req` in the cycle after `cmd_ack`. A `cmd_req` that is high in IDLE is always a new command.
  - `cmd_req` is ignored in every state except IDLE. There is no queueing.
- `violation` outside STROBE is ignored by this block.
- Reset (including mid-command):
  - State goes to IDLE; counter, error flag and registered op are cleared.
  - All outputs are 0, except `key_in`, which follows `kdf_data`.
  - No partial key completion happens after reset.

## Timing
- Let T be the IDLE cycle in which `cmd_req` is sampled high.
- Protect: strobe at T+1, `kdf_start` at T+2, KEYGEN from T+3.
  - With `kdf_valid` constantly high and KEY_IDX_SIZE=3: words idx 0..7 at T+3..T+10, `cmd_ack` at T+11.
  - Each cycle `kdf_valid` is low adds one cycle.
- Unprotect/attest: strobe at T+1, `cmd_ack` at T+2.
- Reserved op: `cmd_ack` with `cmd_err=1` at T+1.
- Violation at strobe: `cmd_ack` with `cmd_err=1` at T+2, and no `kdf_start`.
- All outputs are registered-state decodes, except `write_key` and `key_in` (combinational from `kdf_valid`/`kdf_data`).

## Configuration
- `OMSP_SPM_KDF_TIMEOUT_EN` defined:
  - A cycle counter runs in KEYGEN.
  - After KDF_TIMEOUT cycles without the final word, go to DONE with `cmd_err=1` and drop `kdf_ready`.
  - Key words already written stay written.
- Undefined: KEYGEN waits indefinitely, and the timeout counter and the `KDF_TIMEOUT` logic are absent.

## Structure
- Shared defines file holds:
  - op codes (`SPM_OP_PROTECT`/`UNPROTECT`/`ATTEST`/`RSVD`);
  - FSM state encodings;
  - the macro default.
- One sub-module, `omsp_spm_key_stream`: word counter, `kdf_ready`/`write_key` handshake, last-word detect and the optional timeout. The FSM stays in `omsp_spm_cmd_seq`.

## Test plan
- Protect, no violation, `kdf_valid` constantly high, `kdf_data` = 0x1000+idx:
  - strobe at T+1 and `kdf_start` at T+2;
  - 8 `write_key` cycles with `key_idx` 0..7 and `key_in` 0x1000..0x1007;
  - `cmd_ack=1`, `cmd_err=0` at T+11.
- Protect with `violation=1` in the strobe cycle → no `kdf_start`; `cmd_ack`, `cmd_err=1` at T+2.
- Unprotect → `update_spm=1`, `disable_spm=1`, `enable_spm=0` at T+1; ack at T+2. Reserved op 11 → ack with err at T+1 and no strobes.
- `kdf_valid` toggling 1,0,1,0 → `key_idx` advances only on valid cycles; ack at T+18.
- `puc_rst_n` low during KEYGEN at word 4 → all outputs 0 immediately. After release, an attest command completes normally with ack at T+2.
- With `OMSP_SPM_KDF_TIMEOUT_EN`, `KDF_TIMEOUT=16`, `kdf_valid` stuck low → `cmd_ack`, `cmd_err=1` 16 cycles after KEYGEN entry, and no `write_key`.
